// File: rtl/dsp_irq_gen.sv
// rtl/dsp_irq_gen.sv - per-channel read-request to DSP interrupt pulse generator with pending queue
// Optional per-slot event statistics are built only when DSP_IRQ_STATS_EN is defined.
module dsp_irq_gen #(
   parameter int NUM_CH    = 4,
   parameter int PULSE_LEN = 100,
   parameter int PEND_W    = 4,
   parameter int CNT_W     = 11
) (
   input  logic                    clk_50m,
   input  logic                    cfg_rst,
   input  logic [NUM_CH-1:0]       read_quest,
   input  logic [NUM_CH-1:0]       irq_mask,
   input  logic                    slot_interrupt,
   output logic [NUM_CH-1:0]       dsp_receive_interrupt,
   output logic [NUM_CH-1:0]       irq_pending,
   output logic [NUM_CH-1:0]       irq_overflow,
   output logic [NUM_CH*CNT_W-1:0] slot_irq_count,
   output logic                    slot_count_valid
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_PULSE = 2'd1;
   localparam logic [1:0] S_GAP   = 2'd2;

   localparam logic [7:0]        LAST     = 8'(PULSE_LEN - 1);
   localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};

   logic [NUM_CH-1:0] rq_d;
   logic              rst_q;
   logic [NUM_CH-1:0] rise;
   logic [NUM_CH-1:0] acc_ok;

   // rst_q blanks the first cycle after release so a level already high is not taken as a rise
   always_ff @(posedge clk_50m) begin
      if (cfg_rst) begin
         rq_d  <= '0;
         rst_q <= 1'b1;
      end else begin
         rq_d  <= read_quest;
         rst_q <= 1'b0;
      end
   end

   assign rise = read_quest & ~rq_d & {NUM_CH{~rst_q}};

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic [1:0]        state;
      logic [7:0]        cnt;
      logic [PEND_W-1:0] pend;
      logic              ovf;
      logic              acc;
      logic              inc;
      logic              dec;
      logic              drop;

      // An edge arriving in GAP with nothing queued restarts the pulse directly (inc and dec cancel)
      always_comb begin
         acc  = rise[i] & ~irq_mask[i];
         inc  = acc & (state != S_IDLE);
         dec  = (state == S_GAP) & ((pend != '0) | acc);
         drop = inc & ~dec & (pend == PEND_MAX);
      end

      always_ff @(posedge clk_50m) begin
         if (cfg_rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            pend  <= '0;
            ovf   <= 1'b0;
         end else if (irq_mask[i]) begin
            state <= S_IDLE;
            cnt   <= '0;
            pend  <= '0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (acc) begin
                     state <= S_PULSE;
                     cnt   <= '0;
                  end
               end
               S_PULSE: begin
                  if (cnt == LAST) begin
                     state <= S_GAP;
                  end else begin
                     cnt <= cnt + 8'd1;
                  end
               end
               S_GAP: begin
                  cnt <= '0;
                  if (dec) begin
                     state <= S_PULSE;
                  end else begin
                     state <= S_IDLE;
                  end
               end
               default: state <= S_IDLE;
            endcase
            if (inc && !dec && !drop) begin
               pend <= pend + PEND_W'(1);
            end else if (dec && !inc) begin
               pend <= pend - PEND_W'(1);
            end
            if (drop) begin
               ovf <= 1'b1;
            end
         end
      end

      assign dsp_receive_interrupt[i] = (state == S_PULSE);
      assign irq_pending[i]           = (pend != '0);
      assign irq_overflow[i]          = ovf;
      assign acc_ok[i]                = acc & ~drop;
   end

`ifdef DSP_IRQ_STATS_EN
   logic [CNT_W-1:0]        ev_cnt [NUM_CH];
   logic [NUM_CH*CNT_W-1:0] slot_q;
   logic                    valid_q;

   always_ff @(posedge clk_50m) begin
      if (cfg_rst) begin
         slot_q  <= '0;
         valid_q <= 1'b0;
         for (int i = 0; i < NUM_CH; i++) begin
            ev_cnt[i] <= '0;
         end
      end else begin
         valid_q <= slot_interrupt;
         for (int i = 0; i < NUM_CH; i++) begin
            if (slot_interrupt) begin
               slot_q[i*CNT_W +: CNT_W] <= ev_cnt[i];
               ev_cnt[i]                <= CNT_W'(acc_ok[i]);
            end else if (acc_ok[i] && (ev_cnt[i] != {CNT_W{1'b1}})) begin
               ev_cnt[i] <= ev_cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   assign slot_irq_count   = slot_q;
   assign slot_count_valid = valid_q;
`else
   logic unused_slot;
   assign unused_slot      = &{1'b0, slot_interrupt, acc_ok};
   assign slot_irq_count   = '0;
   assign slot_count_valid = 1'b0;
`endif

endmodule

// File: doc/dsp_irq_gen.md
DSP_IRQ_GEN -- requirements
Module: dsp_irq_gen

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent request/interrupt channels (1..16).
REQ-002 Parameter PULSE_LEN, default 100: interrupt pulse length in clk_50m cycles (2..255).
REQ-003 Parameter PEND_W, default 4: width of each channel's pending-request counter.
REQ-004 Parameter CNT_W, default 11: width of each channel's per-slot event counter.
REQ-005 clk_50m  input  1  sole clock; all logic on its rising edge.
REQ-006 cfg_rst  input  1  reset, synchronous, active-high.
REQ-007 read_quest  input  NUM_CH  per-channel read request level, synchronous to clk_50m.
REQ-008 irq_mask  input  NUM_CH  1 = channel disabled.
REQ-009 slot_interrupt  input  1  slot boundary strobe, one cycle.
REQ-010 dsp_receive_interrupt  output  NUM_CH  per-channel interrupt pulse to DSP.
REQ-011 irq_pending  output  NUM_CH  1 = channel pending counter nonzero.
REQ-012 irq_overflow  output  NUM_CH  sticky; pending counter saturated and an edge was lost.
REQ-013 slot_irq_count  output  NUM_CH*CNT_W  per-channel event count latched at last slot boundary; channel i at bits [i*CNT_W +: CNT_W].
REQ-014 slot_count_valid  output  1  one-cycle strobe when slot_irq_count updates.

Function
REQ-015 Each channel SHALL register read_quest into a delay flop; edge = read_quest & ~delayed, evaluated combinationally in the same cycle.
REQ-016 Each channel SHALL run an FSM with states IDLE, PULSE, GAP.
REQ-017 IDLE: on an edge with the pending counter at 0, go to PULSE; dsp_receive_interrupt is high from the next cycle, giving one-cycle latency from read_quest sampled high.
REQ-018 PULSE: output high for exactly PULSE_LEN cycles, then go to GAP.
REQ-019 GAP: output low for exactly 1 cycle; then go to PULSE and decrement pending if pending > 0, else go to IDLE.
REQ-020 An edge in PULSE or GAP, or in IDLE with pending > 0, SHALL increment pending.
REQ-021 An edge and a decrement in the same cycle SHALL leave pending unchanged.
REQ-022 Pending SHALL saturate at 2^PEND_W-1; an edge arriving at saturation SHALL be dropped and SHALL set irq_overflow.
REQ-023 A masked channel SHALL ignore edges. Asserting irq_mask SHALL force IDLE, clear pending and drive the output low on the next cycle. irq_overflow is not cleared.
REQ-024 Channels SHALL be fully independent; simultaneous edges on all channels SHALL each be serviced.

Reset
REQ-025 On cfg_rst high at a clock edge, the following SHALL clear: all FSMs to IDLE, delay flops, pending, irq_overflow, dsp_receive_interrupt, slot counters, slot_irq_count and slot_count_valid.
REQ-026 Reset asserted mid-pulse SHALL drop the output on the next edge; no pulse resumes after release.
REQ-027 A read_quest already high at reset release SHALL NOT produce an edge.

Configuration
REQ-028 Macro DSP_IRQ_STATS_EN: when defined, each channel counts accepted, unmasked edges (saturating at 2^CNT_W-1).
REQ-029 With DSP_IRQ_STATS_EN defined, on slot_interrupt the count SHALL be copied to slot_irq_count and the counter reset to 0, or to 1 if an edge occurs that same cycle; slot_count_valid pulses the following cycle.
REQ-030 Without DSP_IRQ_STATS_EN, slot_irq_count and slot_count_valid SHALL be constant 0, no counter logic is present, and slot_interrupt is ignored.

Verification
REQ-031 PULSE_LEN=100; rise read_quest[0] at cycle 10 -> irq[0] high cycles 11..110, low at 111, IDLE at 112.
REQ-032 Three edges on ch0 during one pulse -> pending reaches 3; four pulses total, each separated by exactly 1 low cycle; irq_pending falls when the last pulse starts.
REQ-033 PEND_W=2; 5 edges during one pulse -> pending 3, irq_overflow[0]=1, four pulses total.
REQ-034 irq_mask[1] set at cycle 50 of a pulse -> irq[1] low next cycle, pending 0; later edges while masked produce no pulse.
REQ-035 DSP_IRQ_STATS_EN defined; 7 edges on ch2, then slot_interrupt coincident with an 8th edge -> slot_irq_count ch2 = 7, slot_count_valid one cycle later, internal count 1.
REQ-036 cfg_rst asserted at cycle 40 of a pulse with pending 2 -> all outputs 0 next cycle; no pulses after release with read_quest held high.
